// File: rtl/calc_result_display_if.sv
`default_nettype none
// ============================================================================
// Module      : calc_result_display_if
// Description : Bundles the calculator result inputs and the seven-segment
//               display outputs of calc_result_display.
// Revision    : 1.0 - initial release
// ============================================================================
interface calc_result_display_if #(
   parameter int N = 4
);
   logic         start;
   logic [1:0]   op_sel;
   logic [N-1:0] r;
   logic         cout;
   logic [N-1:0] quotient;
   logic         error_div;
   logic [N-1:0] remainder_mod;
   logic         error_mod;
   logic [6:0]   seg;
   logic [1:0]   an;
   logic         busy;
   logic         valid;

   // Calculator side: drives operands/results, observes the display
   modport master (
      output start, op_sel, r, cout, quotient, error_div, remainder_mod, error_mod,
      input  seg, an, busy, valid
   );

   // Display stage side
   modport slave (
      input  start, op_sel, r, cout, quotient, error_div, remainder_mod, error_mod,
      output seg, an, busy, valid
   );
endinterface
`default_nettype wire

// File: rtl/calc_result_display.sv
`default_nettype none
// ============================================================================
// Module      : calc_result_display
// Description : Captures the selected calculator result/flag on a start
//               strobe and shows it on a 2-digit multiplexed active-low
//               seven-segment display (digit 0 = result, digit 1 = flag).
// Revision    : 1.0 - initial release
// ============================================================================
module calc_result_display #(
   parameter int N           = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  wire                  clk,
   input  wire                  rst,
   calc_result_display_if.slave bus
);

   localparam int         c_CNT_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [6:0] c_BLANK  = 7'b1111111;
   localparam logic [6:0] c_DASH   = 7'b0111111;
   localparam logic [6:0] c_E      = 7'b0000110;
   localparam logic [6:0] c_ONE    = 7'b1111001;
   localparam logic [6:0] c_ZERO   = 7'b1000000;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LATCH = 2'd1,
      SHOW  = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [N-1:0]     r_result;
   logic             r_flag;
   logic             r_err;
   logic             r_is_sub;
   logic [c_CNT_W-1:0] r_cnt;
   logic             r_sel;
   logic [6:0]       r_seg;
   logic [1:0]       r_an;
   logic             r_busy;
   logic             r_valid;
   logic [6:0]       w_seg_d;
   logic [1:0]       w_an_d;
   logic [6:0]       w_hex_glyph;
   logic [3:0]       w_hex;

   // Standard hex glyphs, active low, bit 0 = segment a
   function automatic logic [6:0] hex_glyph(input logic [3:0] v);
      case (v)
         4'h0: hex_glyph = 7'b1000000;
         4'h1: hex_glyph = 7'b1111001;
         4'h2: hex_glyph = 7'b0100100;
         4'h3: hex_glyph = 7'b0110000;
         4'h4: hex_glyph = 7'b0011001;
         4'h5: hex_glyph = 7'b0010010;
         4'h6: hex_glyph = 7'b0000010;
         4'h7: hex_glyph = 7'b1111000;
         4'h8: hex_glyph = 7'b0000000;
         4'h9: hex_glyph = 7'b0010000;
         4'hA: hex_glyph = 7'b0001000;
         4'hB: hex_glyph = 7'b0000011;
         4'hC: hex_glyph = 7'b1000110;
         4'hD: hex_glyph = 7'b0100001;
         4'hE: hex_glyph = 7'b0000110;
         default: hex_glyph = 7'b0001110;
      endcase
   endfunction

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic and the display word that will be registered next edge
   always_comb begin
      w_next      = r_state;
      w_hex       = 4'(r_result);
      w_hex_glyph = hex_glyph(w_hex);
      w_seg_d     = c_BLANK;
      w_an_d      = 2'b11;
      case (r_state)
         IDLE:    if (bus.start) w_next = LATCH;
         LATCH:   w_next = SHOW;
         SHOW: begin
            if (bus.start) w_next = LATCH;
            if (!r_sel) begin
               w_an_d  = 2'b10;
               w_seg_d = r_err ? c_DASH : w_hex_glyph;
            end else begin
               w_an_d = 2'b01;
               if (r_err)         w_seg_d = c_E;
               else if (r_is_sub) w_seg_d = r_flag ? c_ONE : c_ZERO;
               else               w_seg_d = c_BLANK;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   // Capture the selected operation's result and status in LATCH only
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_result <= '0;
         r_flag   <= 1'b0;
         r_err    <= 1'b0;
         r_is_sub <= 1'b0;
      end else if (r_state == LATCH) begin
         case (bus.op_sel)
            2'b01: begin
               r_result <= bus.quotient;
               r_flag   <= 1'b0;
               r_err    <= bus.error_div;
               r_is_sub <= 1'b0;
            end
            2'b10: begin
               r_result <= bus.remainder_mod;
               r_flag   <= 1'b0;
               r_err    <= bus.error_mod;
               r_is_sub <= 1'b0;
            end
            default: begin
               r_result <= bus.r;
               r_flag   <= bus.cout;
               r_err    <= 1'b0;
               r_is_sub <= 1'b1;
            end
         endcase
      end
   end

   // Refresh counter and digit select: restart on capture, run while showing
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_sel <= 1'b0;
      end else if (r_state == LATCH) begin
         r_cnt <= '0;
         r_sel <= 1'b0;
      end else if (r_state == SHOW) begin
         if (r_cnt == c_CNT_W'(REFRESH_DIV - 1)) begin
            r_cnt <= '0;
            r_sel <= ~r_sel;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   // Registered outputs: glyph and anode update together on the same edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_seg   <= c_BLANK;
         r_an    <= 2'b11;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
      end else begin
         r_seg   <= w_seg_d;
         r_an    <= w_an_d;
         r_busy  <= (w_next == LATCH);
         r_valid <= (r_state == SHOW);
      end
   end

   assign bus.seg   = r_seg;
   assign bus.an    = r_an;
   assign bus.busy  = r_busy;
   assign bus.valid = r_valid;

endmodule
`default_nettype wire
